rpn_msg_type_router: RTL and testbench
======================================

# rpn_msg_type_router

Parametrised, packet-aware AXI-Stream router that receives reliability-protocol (RPN) messages from the network bridge and steers each whole packet to one of `NUM_OUTPUTS` downstream consumers (sequence-number initializer, WNN outgoing repo, WNN incoming repo, and future consumers) by message-type range. It latches the routing decision on the head beat and holds it until `tlast`. It drops packets whose type matches no range, and registers the output through a two-entry skid buffer so the input `tready` does not depend combinationally on any output `tready`. It sits between the network bridge and the RPN consumer modules.

## Interface
- `NUM_OUTPUTS`, 3, number of output channels (1..8).
- `AXIS_DATA_WIDTH`, 64, tdata width.
- `AXIS_KEEP_WIDTH`, `AXIS_DATA_WIDTH/8`, tkeep width.
- `AXIS_FROM_NB_TDEST_WIDTH`, 16, tid/tdest width.
- `AXIS_FROM_NB_TUSER_WIDTH`, 16, tuser width.
- `RPN_MSG_TYPE_WIDTH`, 8, message-type field width; the field is `tdata[RPN_MSG_TYPE_WIDTH-1:0]` of the head beat.
- `RANGE_LO`, 0, packed `NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH`; slice i is the inclusive lower type bound of output i.
- `RANGE_HI`, all ones, packed; slice i is the inclusive upper type bound of output i.

Ports:
- `i_clk` in 1: the only clock.
- `i_ap_rst_n` in 1: reset, synchronous, active-low.
- `from_network_bridge_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}`: AXIS slave; tready is the only output.
- `to_consumer_tvalid` out `NUM_OUTPUTS`: per-channel valid.
- `to_consumer_tready` in `NUM_OUTPUTS`: per-channel ready.
- `to_consumer_{tdata,tkeep,tid,tdest,tuser,tlast}` out: a single shared bus, meaningful only on the asserted valid bit.
- `o_drop_pulse` out 1: one-cycle pulse when an unmatched head beat is accepted.
- `o_drop_count` out 32: count of dropped packets.
- `o_pkt_count` out `NUM_OUTPUTS*32`: per-output count of forwarded packets.

## Operation
- Decode: on a head beat, output i matches when `RANGE_LO[i] <= type <= RANGE_HI[i]`. The lowest matching index wins. No match means drop.
- FSM states and transitions:
  - HEAD (reset state). On an accepted head beat:
    - Match: push the beat tagged with route index i; go to FWD, unless tlast is set, in which case stay in HEAD.
    - No match: pulse `o_drop_pulse`, increment the drop count; go to DROP, unless tlast is set, in which case stay in HEAD.
  - FWD: push each accepted beat with the latched route. Return to HEAD on an accepted tlast. Type bits of non-head beats are ignored.
  - DROP: discard accepted beats. Return to HEAD on an accepted tlast.
- Skid buffer: two entries, each holding {beat, route index}. The head entry drives the shared bus. `to_consumer_tvalid[route]` equals entry-valid; all other bits are 0. The entry pops when `to_consumer_tready[route]` is high. Ready bits of non-selected outputs are ignored.
- `from_network_bridge_tready` is a register equal to "the skid buffer will have at least one free entry next cycle", with one exception: in DROP it is forced to 1.
- Packet counters increment when a beat with tlast pops to output i.
- All counters saturate at 0xFFFF_FFFF; they do not wrap.

## Timing
- Latency: one cycle from input acceptance to output tvalid.
- Throughput: one beat per cycle while the selected consumer holds tready high.
- Output stability: once tvalid is asserted, tdata, side-band signals and the route index stay stable until the beat is accepted (AXIS rule).
- Consumer stall: at most 2 beats are absorbed after the stall, then input tready deasserts in the following cycle. No beat is lost.
- Push and pop in the same cycle with the buffer full: this is legal; occupancy stays at 2.
- Drop while output beats are pending: the pending beats still drain in order.
- Reset values: all tvalid bits 0; `from_network_bridge_tready` 0 during reset and 1 on the first cycle after release; `o_drop_pulse` 0; all counts 0; FSM in HEAD.
- Reset mid-packet: the buffer is flushed and the FSM returns to HEAD. The next beat is treated as a head beat; recovery is the upstream's responsibility.

## Configuration
- `RPN_ROUTER_STATS_EN`:
  - Defined: `o_drop_count` and `o_pkt_count` are implemented as described above.
  - Not defined: the counters are not instantiated and both ports are tied to 0. `o_drop_pulse` and the drop behaviour stay present in both builds.

## Structure
- Shared package `rpn_router_pkg`:
  - FSM state enum `rpn_router_state_t` (HEAD, FWD, DROP).
  - Skid-entry struct `{beat, route}`.
  - Function `rpn_route_decode(type, RANGE_LO, RANGE_HI)` returning {hit, index}.
- One natural sub-module: `rpn_axis_skid_buffer`, a two-entry buffer with a generic payload width.

## Test plan
- Range steering: ranges 0–3 / 4–7 / 8–15; send single-beat packets of types 2, 5, 12 → each appears exactly once on outputs 0, 1, 2 respectively, after 1 cycle, with tdata intact.
- Route latching: 4-beat packet of type 5 whose later beats carry type 0 in their low bits → all 4 beats go to output 1, and tlast is seen only on beat 4.
- Drop: 3-beat packet of type 200 → no output tvalid, `o_drop_pulse` high for exactly 1 cycle, drop count 1, input tready held at 1 for all 3 beats.
- Backpressure: hold `to_consumer_tready[2]` low while streaming 6 beats to output 2 → input tready falls after 2 beats; on release, all 6 beats arrive in order with no duplicates.
- Overlap priority: ranges 0–10 / 5–15; type 7 → output 0 only.
- Reset: assert reset in the middle of a 4-beat packet → all tvalid bits and counts are 0 within one cycle; the first post-reset beat is routed as a head beat.

Source files
------------

// File: rtl/rpn_msg_type_router_pkg.sv
// rpn_msg_type_router_pkg: shared FSM state, route type and message-type range decoder for the RPN router
package rpn_router_pkg;
  localparam int RPN_MAX_OUTPUTS = 8;
  localparam int RPN_MAX_TYPE_W = 32;
  localparam int RPN_ROUTE_W = 3;
  localparam int RPN_RANGE_W = RPN_MAX_OUTPUTS * RPN_MAX_TYPE_W;
  typedef enum logic [1:0] {HEAD, FWD, DROP} rpn_router_state_t;
  typedef struct packed {
    logic                   hit;
    logic [RPN_ROUTE_W-1:0] idx;
  } rpn_route_t;
  // Lowest matching output wins, so scan from the top index down and let lower hits overwrite.
  function automatic rpn_route_t rpn_route_decode(
    input logic [RPN_MAX_TYPE_W-1:0] msg_type,
    input logic [RPN_RANGE_W-1:0]    range_lo,
    input logic [RPN_RANGE_W-1:0]    range_hi,
    input int                        num_outputs,
    input int                        type_w
  );
    rpn_route_t r;
    logic [RPN_MAX_TYPE_W-1:0] mask, lo, hi, t;
    r = '0;
    mask = (type_w >= RPN_MAX_TYPE_W) ? '1 : (RPN_MAX_TYPE_W'(1) << type_w) - RPN_MAX_TYPE_W'(1);
    t = msg_type & mask;
    for (int i = RPN_MAX_OUTPUTS - 1; i >= 0; i--) begin
      lo = RPN_MAX_TYPE_W'(range_lo >> (i * type_w)) & mask;
      hi = RPN_MAX_TYPE_W'(range_hi >> (i * type_w)) & mask;
      if (i < num_outputs && t >= lo && t <= hi) begin
        r.hit = 1'b1;
        r.idx = RPN_ROUTE_W'(i);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rpn_msg_type_router_if.sv
// rpn_msg_type_router_if: AXI-Stream bundle with an N-bit valid/ready pair and one shared payload bus
interface rpn_msg_type_router_if #(
  parameter int N      = 1,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 16,
  parameter int USER_W = 16
) ();
  logic [N-1:0]      tvalid;
  logic [N-1:0]      tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [ID_W-1:0]   tid;
  logic [ID_W-1:0]   tdest;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  modport master (output tvalid, tdata, tkeep, tid, tdest, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/rpn_axis_skid_buffer.sv
// rpn_axis_skid_buffer: two-entry in-order buffer with generic payload and look-ahead free flag
module rpn_axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_next_o
);
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic             pop;
  assign valid_o     = count_q != 2'd0;
  assign data_o      = ent0_q;
  assign pop         = valid_o && ready_i;
  assign free_next_o = count_d != 2'd2;
  // Entry 0 is the head; a push lands in whichever slot is first free after this cycle's pop.
  always_comb begin
    count_d = count_q + 2'(push_i) - 2'(pop);
    ent0_d  = (count_q == 2'd0 || (pop && count_q == 2'd1)) ? data_i : (pop ? ent1_q : ent0_q);
    ent1_d  = (push_i && (count_q - 2'(pop)) == 2'd1) ? data_i : ent1_q;
  end
  // Occupancy is the only state that needs reset; a flush simply empties the buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count_q <= 2'd0;
    else count_q <= count_d;
  end
  // Payload storage, qualified by occupancy.
  always_ff @(posedge clk_i) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end
endmodule

// File: rtl/rpn_msg_type_router.sv
// rpn_msg_type_router: packet-aware AXIS router steering RPN messages by type range; RPN_ROUTER_STATS_EN enables drop/packet counters
module rpn_msg_type_router
  import rpn_router_pkg::*;
#(
  parameter int NUM_OUTPUTS              = 3,
  parameter int AXIS_DATA_WIDTH          = 64,
  parameter int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_FROM_NB_TDEST_WIDTH = 16,
  parameter int AXIS_FROM_NB_TUSER_WIDTH = 16,
  parameter int RPN_MSG_TYPE_WIDTH       = 8,
  parameter logic [NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH-1:0] RANGE_LO = '0,
  parameter logic [NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH-1:0] RANGE_HI = '1
) (
  input  logic                      i_clk,
  input  logic                      i_ap_rst_n,
  rpn_msg_type_router_if.slave      from_network_bridge,
  rpn_msg_type_router_if.master     to_consumer,
  output logic                      o_drop_pulse,
  output logic [31:0]               o_drop_count,
  output logic [NUM_OUTPUTS*32-1:0] o_pkt_count
);
  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]          tdata;
    logic [AXIS_KEEP_WIDTH-1:0]          tkeep;
    logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] tid;
    logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] tdest;
    logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] tuser;
    logic                                tlast;
  } beat_t;
  typedef struct packed {
    beat_t                  beat;
    logic [RPN_ROUTE_W-1:0] route;
  } entry_t;
  rpn_router_state_t      state_q, state_d;
  logic [RPN_ROUTE_W-1:0] route_q, route_d;
  logic                   ready_q, ready_d, drop_pulse_q, drop_pulse_d;
  logic                   accept, push, free_next, head_valid, sel_ready;
  entry_t                 push_entry, head_entry;
  rpn_route_t             dec;
  assign accept = from_network_bridge.tvalid[0] && ready_q;
  assign from_network_bridge.tready = ready_q;
  assign o_drop_pulse = drop_pulse_q;
  assign dec = rpn_route_decode(RPN_MAX_TYPE_W'(from_network_bridge.tdata[RPN_MSG_TYPE_WIDTH-1:0]),
                                RPN_RANGE_W'(RANGE_LO), RPN_RANGE_W'(RANGE_HI),
                                NUM_OUTPUTS, RPN_MSG_TYPE_WIDTH);
  assign push_entry = {from_network_bridge.tdata, from_network_bridge.tkeep, from_network_bridge.tid,
                       from_network_bridge.tdest, from_network_bridge.tuser, from_network_bridge.tlast, route_d};
  // Dropping never touches the buffer, so input ready is forced high for the whole dropped packet.
  assign ready_d = (state_d == DROP) || free_next;
  // Packet FSM: the head beat picks the route (or drop), later beats follow it until tlast.
  always_comb begin
    state_d      = state_q;
    route_d      = route_q;
    push         = 1'b0;
    drop_pulse_d = 1'b0;
    case (state_q)
      HEAD: if (accept) begin
        push         = dec.hit;
        route_d      = dec.idx;
        drop_pulse_d = !dec.hit;
        state_d      = from_network_bridge.tlast ? HEAD : (dec.hit ? FWD : DROP);
      end
      FWD: begin
        push    = accept;
        state_d = (accept && from_network_bridge.tlast) ? HEAD : FWD;
      end
      DROP: state_d = (accept && from_network_bridge.tlast) ? HEAD : DROP;
      default: state_d = HEAD;
    endcase
  end
  // State, latched route, registered input ready and drop pulse.
  always_ff @(posedge i_clk) begin
    if (!i_ap_rst_n) begin
      state_q      <= HEAD;
      route_q      <= '0;
      ready_q      <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      route_q      <= route_d;
      ready_q      <= ready_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end
  rpn_axis_skid_buffer #(.WIDTH($bits(entry_t))) u_skid (
    .clk_i       (i_clk),
    .rst_n_i     (i_ap_rst_n),
    .push_i      (push),
    .data_i      (push_entry),
    .ready_i     (sel_ready),
    .valid_o     (head_valid),
    .data_o      (head_entry),
    .free_next_o (free_next)
  );
  assign sel_ready = |(to_consumer.tready & (NUM_OUTPUTS'(1) << head_entry.route));
  assign to_consumer.tvalid = head_valid ? (NUM_OUTPUTS'(1) << head_entry.route) : '0;
  assign {to_consumer.tdata, to_consumer.tkeep, to_consumer.tid,
          to_consumer.tdest, to_consumer.tuser, to_consumer.tlast} = head_entry.beat;
`ifdef RPN_ROUTER_STATS_EN
  logic                         pkt_done;
  logic [31:0]                  drop_count_q;
  logic [NUM_OUTPUTS-1:0][31:0] pkt_count_q;
  assign pkt_done     = head_valid && sel_ready && head_entry.beat.tlast;
  assign o_drop_count = drop_count_q;
  assign o_pkt_count  = pkt_count_q;
  // Saturating drop and per-output packet counters.
  always_ff @(posedge i_clk) begin
    if (!i_ap_rst_n) begin
      drop_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      if (drop_pulse_d && drop_count_q != '1) drop_count_q <= drop_count_q + 32'd1;
      for (int k = 0; k < NUM_OUTPUTS; k++)
        if (pkt_done && head_entry.route == RPN_ROUTE_W'(k) && pkt_count_q[k] != '1)
          pkt_count_q[k] <= pkt_count_q[k] + 32'd1;
    end
  end
`else
  assign o_drop_count = '0;
  assign o_pkt_count  = '0;
`endif
endmodule

// File: tb/tb_rpn_msg_type_router.sv
// tb_rpn_msg_type_router: directed stimulus with a transaction-level scoreboard checking the router every cycle
module tb_rpn_msg_type_router;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  rpn_msg_type_router_if #(.N(1)) nb ();
  rpn_msg_type_router_if #(.N(3)) cs ();
  rpn_msg_type_router_if #(.N(1)) nb2 ();
  rpn_msg_type_router_if #(.N(2)) cs2 ();
  logic        drop_pulse, dp2;
  logic [31:0] drop_count, dc2;
  logic [95:0] pkt_count;
  logic [63:0] pc2;
  rpn_msg_type_router #(
    .RANGE_LO({8'd8, 8'd4, 8'd0}),
    .RANGE_HI({8'd15, 8'd7, 8'd3})
  ) dut (
    .i_clk(clk), .i_ap_rst_n(rst_n), .from_network_bridge(nb), .to_consumer(cs),
    .o_drop_pulse(drop_pulse), .o_drop_count(drop_count), .o_pkt_count(pkt_count)
  );
  rpn_msg_type_router #(
    .NUM_OUTPUTS(2),
    .RANGE_LO({8'd5, 8'd0}),
    .RANGE_HI({8'd15, 8'd10})
  ) dut2 (
    .i_clk(clk), .i_ap_rst_n(rst_n), .from_network_bridge(nb2), .to_consumer(cs2),
    .o_drop_pulse(dp2), .o_drop_count(dc2), .o_pkt_count(pc2)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic [15:0] u;
    logic        last;
    int          r;
  } exp_t;
  exp_t q[$];
  int lo[3] = '{0, 4, 8};
  int hi[3] = '{3, 7, 15};
  bit in_pkt = 0, pulse_exp = 0, rst_seen = 0;
  int cur = -1, drop_cnt = 0, acc_cnt = 0;
  int pkt_cnt[3] = '{0, 0, 0};

  function automatic int route_of(input int t);
    for (int i = 0; i < 3; i++) if (t >= lo[i] && t <= hi[i]) return i;
    return -1;
  endfunction

  // Scoreboard: compare the visible outputs, then account for the pop/push happening at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (rst_seen) begin
        chk("rst_tvalid", cs.tvalid, 0);
        chk("rst_tready", nb.tready, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_pkt_count", pkt_count, 0);
      end
      rst_seen = 1;
      q.delete();
      in_pkt = 0;
      pulse_exp = 0;
      drop_cnt = 0;
      pkt_cnt = '{0, 0, 0};
    end else begin
      rst_seen = 0;
      if (q.size() != 0) begin
        chk("out_tvalid", cs.tvalid, 3'b001 << q[0].r);
        chk("out_tdata", cs.tdata, q[0].d);
        chk("out_tuser", cs.tuser, q[0].u);
        chk("out_tlast", cs.tlast, q[0].last);
      end else chk("out_idle", cs.tvalid, 0);
      chk("drop_pulse", drop_pulse, pulse_exp);
`ifdef RPN_ROUTER_STATS_EN
      chk("drop_count", drop_count, 32'(drop_cnt));
      chk("pkt_count", pkt_count, {32'(pkt_cnt[2]), 32'(pkt_cnt[1]), 32'(pkt_cnt[0])});
`else
      chk("drop_count_off", drop_count, 0);
      chk("pkt_count_off", pkt_count, 0);
`endif
      pulse_exp = 0;
      if (q.size() != 0 && cs.tready[q[0].r]) begin
        if (q[0].last) pkt_cnt[q[0].r]++;
        void'(q.pop_front());
      end
      if (nb.tvalid[0] && nb.tready[0]) begin
        acc_cnt++;
        if (!in_pkt) begin
          cur = route_of(int'(nb.tdata[7:0]));
          if (cur < 0) begin
            pulse_exp = 1;
            drop_cnt++;
          end
        end
        if (cur >= 0) q.push_back('{d: nb.tdata, u: nb.tuser, last: nb.tlast, r: cur});
        in_pkt = !nb.tlast;
      end
    end
  end

  task automatic send(input logic [7:0] t, input logic [7:0] k, input logic last);
    bit ok = 0;
    nb.tvalid = 1'b1;
    nb.tdata = {k, 48'h123456789ABC, t};
    nb.tuser = {k, t} ^ 16'h5A5A;
    nb.tkeep = 8'hFF;
    nb.tid = 16'h0011;
    nb.tdest = 16'h0022;
    nb.tlast = last;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = nb.tready[0];
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    nb.tvalid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] t);
    bit ok = 0;
    nb2.tvalid = 1'b1;
    nb2.tdata = {56'h0, t};
    nb2.tlast = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = nb2.tready[0];
    end
    if (!ok) chk("send2_timeout", 0, 1);
    @(posedge clk);
    #1;
    nb2.tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done = 0;
    int base;
    nb.tvalid = 0; nb.tdata = 0; nb.tkeep = 0; nb.tid = 0; nb.tdest = 0; nb.tuser = 0; nb.tlast = 0;
    nb2.tvalid = 0; nb2.tdata = 0; nb2.tkeep = 0; nb2.tid = 0; nb2.tdest = 0; nb2.tuser = 0; nb2.tlast = 0;
    cs.tready = 3'b111;
    cs2.tready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", nb.tready, 0);
    chk("reset_valid", cs.tvalid, 0);
    chk("reset_pulse", drop_pulse, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", nb.tready, 1);
    send(8'd2, 8'd0, 1'b1);
    chk("steer2_valid", cs.tvalid, 3'b001);
    chk("steer2_data", cs.tdata, 64'h00123456789ABC02);
    send(8'd5, 8'd1, 1'b1);
    chk("steer5_valid", cs.tvalid, 3'b010);
    chk("steer5_data", cs.tdata, 64'h01123456789ABC05);
    send(8'd12, 8'd2, 1'b1);
    chk("steer12_valid", cs.tvalid, 3'b100);
    chk("steer12_data", cs.tdata, 64'h02123456789ABC0C);
    @(posedge clk);
    #1;
    chk("steer_once", cs.tvalid, 3'b000);
    for (int k = 0; k < 4; k++) begin
      send(k == 0 ? 8'd5 : 8'd0, 8'(k), k == 3);
      chk("latch_valid", cs.tvalid, 3'b010);
      chk("latch_last", cs.tlast, k == 3);
    end
    for (int k = 0; k < 3; k++) begin
      chk("drop_ready", nb.tready, 1);
      send(8'd200, 8'(k), k == 2);
      chk("drop_no_valid", cs.tvalid, 3'b000);
      chk("drop_pulse_once", drop_pulse, k == 0);
    end
`ifdef RPN_ROUTER_STATS_EN
    chk("drop_count_lit", drop_count, 1);
    chk("pkt_count_lit", pkt_count, {32'd1, 32'd2, 32'd1});
`endif
    cs.tready = 3'b011;
    base = acc_cnt;
    fork
      begin
        for (int k = 0; k < 6; k++) send(k == 0 ? 8'd12 : 8'd0, 8'(k), k == 5);
        done = 1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_absorbed", acc_cnt - base, 2);
    chk("bp_ready_low", nb.tready, 0);
    chk("bp_valid_held", cs.tvalid, 3'b100);
    chk("bp_head_data", cs.tdata, 64'h00123456789ABC0C);
    cs.tready = 3'b111;
    for (int n = 0; n < 100 && !done; n++) @(posedge clk);
    chk("bp_done", done, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drained", cs.tvalid, 3'b000);
    chk("bp_total_beats", acc_cnt - base, 6);
`ifdef RPN_ROUTER_STATS_EN
    chk("bp_pkt_count", pkt_count, {32'd2, 32'd2, 32'd1});
`endif
    send(8'd2, 8'd0, 1'b0);
    send(8'd0, 8'd1, 1'b0);
    chk("midrst_pre_valid", cs.tvalid, 3'b001);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", cs.tvalid, 3'b000);
    chk("midrst_ready", nb.tready, 0);
    chk("midrst_drop_count", drop_count, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'd5, 8'd9, 1'b1);
    chk("postrst_head_valid", cs.tvalid, 3'b010);
    chk("postrst_head_data", cs.tdata, 64'h09123456789ABC05);
    send2(8'd7);
    chk("overlap_t7", cs2.tvalid, 2'b01);
    send2(8'd12);
    chk("overlap_t12", cs2.tvalid, 2'b10);
    send2(8'd20);
    chk("overlap_drop_valid", cs2.tvalid, 2'b00);
    chk("overlap_drop_pulse", dp2, 1);
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
